// File: rtl/deco_pkg.sv
// Shared types and helpers for the sequential 3-to-8 decoder.
package deco_pkg;

    localparam int CODE_W = 3;
    localparam int OUT_W  = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    // Decode a 3-bit code into its one-hot 8-bit word (code 0 -> bit 0).
    function automatic logic [OUT_W-1:0] onehot8(input logic [CODE_W-1:0] code);
        logic [OUT_W-1:0] one;
        one = OUT_W'(1);
        return one << code;
    endfunction

endpackage

// File: rtl/deco_3x8_seq_sync_fifo.sv
// Small synchronous FIFO with first-word fall-through read data.
// Handshake: a push writes din when push is high and the FIFO is not full;
// a pop retires dout when pop is high and the FIFO is not empty.
module sync_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Storage array; no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/deco_3x8_seq.sv
// Sequential 3-to-8 decoder: buffers incoming codes and replays each as a
// one-hot word held for HOLD cycles. Optional sticky drop flag `ovf` is built
// only when DECO_OVF_EN is defined.
// Handshake: a code transfers on a rising edge with d_in_valid && d_in_ready;
// d_in_ready depends only on registered count, never on d_in_valid.
module deco_3x8_seq
    import deco_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int HOLD  = 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] d_in,
    input  logic              d_in_valid,
    output logic              d_in_ready,
    output logic [OUT_W-1:0]  d_out,
    output logic              d_out_valid,
    output logic [CNT_W-1:0]  count
`ifdef DECO_OVF_EN
    ,
    output logic              ovf
`endif
);

    localparam int HOLD_W = 4;

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [OUT_W-1:0]  d_out_q, d_out_d;
    logic              valid_q;
    logic              push, pop;
    logic              fifo_full, fifo_empty;
    logic [CODE_W-1:0] fifo_dout;

    assign d_in_ready  = !fifo_full;
    assign push        = d_in_valid && d_in_ready;
    assign d_out       = d_out_q;
    assign d_out_valid = valid_q;

    sync_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (d_in),
        .dout  (fifo_dout),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state logic: pop a code whenever the current word has expired.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        d_out_d = d_out_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                d_out_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    d_out_d = onehot8(fifo_dout);
                    hold_d  = HOLD_W'(HOLD - 1);
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    d_out_d = onehot8(fifo_dout);
                    hold_d  = HOLD_W'(HOLD - 1);
                end else begin
                    d_out_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                d_out_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, hold counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            d_out_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            d_out_q <= d_out_d;
            valid_q <= (state_d == ST_DRIVE);
        end
    end

`ifdef DECO_OVF_EN
    logic ovf_q;
    assign ovf = ovf_q;

    // Sticky flag for any code offered while the FIFO was full.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (d_in_valid && !d_in_ready) begin
            ovf_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_deco_3x8_seq.sv
// Directed bench for deco_3x8_seq: three instances (HOLD = 1, 3, 15) share
// the stimulus; each scenario resets them and checks the relevant instance.
module tb_deco_3x8_seq;

    logic       clk;
    logic       rst;
    logic [2:0] d_in;
    logic       d_in_valid;

    logic       rdy_a, val_a, ovf_a;
    logic [7:0] out_a;
    logic [2:0] cnt_a;
    logic       rdy_b, val_b, ovf_b;
    logic [7:0] out_b;
    logic [2:0] cnt_b;
    logic       rdy_c, val_c, ovf_c;
    logic [7:0] out_c;
    logic [2:0] cnt_c;

    int total;
    int bad;

    // Clock and reset defaults.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    deco_3x8_seq #(.DEPTH(4), .HOLD(1)) u_h1 (
        .clk(clk), .rst(rst), .d_in(d_in), .d_in_valid(d_in_valid),
        .d_in_ready(rdy_a), .d_out(out_a), .d_out_valid(val_a), .count(cnt_a)
`ifdef DECO_OVF_EN
        , .ovf(ovf_a)
`endif
    );

    deco_3x8_seq #(.DEPTH(4), .HOLD(3)) u_h3 (
        .clk(clk), .rst(rst), .d_in(d_in), .d_in_valid(d_in_valid),
        .d_in_ready(rdy_b), .d_out(out_b), .d_out_valid(val_b), .count(cnt_b)
`ifdef DECO_OVF_EN
        , .ovf(ovf_b)
`endif
    );

    deco_3x8_seq #(.DEPTH(4), .HOLD(15)) u_h15 (
        .clk(clk), .rst(rst), .d_in(d_in), .d_in_valid(d_in_valid),
        .d_in_ready(rdy_c), .d_out(out_c), .d_out_valid(val_c), .count(cnt_c)
`ifdef DECO_OVF_EN
        , .ovf(ovf_c)
`endif
    );

`ifndef DECO_OVF_EN
    assign ovf_a = 1'b0;
    assign ovf_b = 1'b0;
    assign ovf_c = 1'b0;
`endif

    // Advance one edge; outputs are observed 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        d_in_valid = 1'b0;
        d_in       = 3'd0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        d_in_valid = 1'b1;
        d_in       = 3'd7;
        step();
        step();
        rst        = 1'b0;
        d_in_valid = 1'b0;
        total++;
        if (out_a !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", out_a); end
        total++;
        if (val_a !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", val_a); end
        total++;
        if (cnt_a !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", cnt_a); end
        total++;
        if (rdy_a !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", rdy_a); end
        total++;
        if (ovf_a !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf_a); end
        total++;
        if (cnt_c !== 3'd0 || out_c !== 8'h00) begin
            bad++; $display("FAIL reset_h15 got cnt=%0d dout=%h exp cnt=0 dout=00", cnt_c, out_c);
        end
    endtask

    task automatic test_single();
        do_reset();
        d_in_valid = 1'b1;
        d_in       = 3'b101;
        step();
        d_in_valid = 1'b0;
        total++;
        if (cnt_a !== 3'd1 || val_a !== 1'b0) begin
            bad++; $display("FAIL single_accept got cnt=%0d valid=%b exp cnt=1 valid=0", cnt_a, val_a);
        end
        step();
        total++;
        if (out_a !== 8'b0010_0000 || val_a !== 1'b1) begin
            bad++; $display("FAIL single_drive got dout=%h valid=%b exp dout=20 valid=1", out_a, val_a);
        end
        total++;
        if (cnt_a !== 3'd0) begin bad++; $display("FAIL single_count got=%0d exp=0", cnt_a); end
        step();
        total++;
        if (out_a !== 8'h00 || val_a !== 1'b0) begin
            bad++; $display("FAIL single_idle got dout=%h valid=%b exp dout=00 valid=0", out_a, val_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] codes [4] = '{3'd7, 3'd6, 3'd5, 3'd4};
        logic [7:0] exp_w [6] = '{8'h00, 8'h80, 8'h40, 8'h20, 8'h10, 8'h00};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                d_in_valid = 1'b1;
                d_in       = codes[i];
            end else begin
                d_in_valid = 1'b0;
            end
            step();
            total++;
            if (out_a !== exp_w[i] || val_a !== (exp_w[i] != 8'h00)) begin
                bad++;
                $display("FAIL burst_word[%0d] got dout=%h valid=%b exp dout=%h valid=%b",
                         i, out_a, val_a, exp_w[i], (exp_w[i] != 8'h00));
            end
        end
        total++;
        if (cnt_a !== 3'd0) begin bad++; $display("FAIL burst_count got=%0d exp=0", cnt_a); end
    endtask

    task automatic test_hold();
        logic [7:0] exp_w [8] = '{8'h00, 8'h04, 8'h04, 8'h04, 8'h01, 8'h01, 8'h01, 8'h00};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                d_in_valid = 1'b1;
                d_in       = 3'b010;
            end else if (i == 1) begin
                d_in_valid = 1'b1;
                d_in       = 3'b000;
            end else begin
                d_in_valid = 1'b0;
            end
            step();
            total++;
            if (out_b !== exp_w[i] || val_b !== (exp_w[i] != 8'h00)) begin
                bad++;
                $display("FAIL hold_word[%0d] got dout=%h valid=%b exp dout=%h valid=%b",
                         i, out_b, val_b, exp_w[i], (exp_w[i] != 8'h00));
            end
            if (i == 1) begin
                total++;
                if (cnt_b !== 3'd1) begin bad++; $display("FAIL hold_count_pp got=%0d exp=1", cnt_b); end
            end
        end
    endtask

    task automatic test_full();
        logic [7:0] words [5]   = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
        logic [2:0] cnt_tab [7] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
        logic [7:0] exp_o;
        do_reset();
        for (int e = 0; e < 77; e++) begin
            if (e < 7) begin
                d_in_valid = 1'b1;
                d_in       = 3'(e + 1);
                total++;
                if (rdy_c !== (e < 5)) begin
                    bad++; $display("FAIL full_ready[%0d] got=%b exp=%b", e, rdy_c, (e < 5));
                end
            end else begin
                d_in_valid = 1'b0;
            end
            step();
            if (e < 7) begin
                total++;
                if (cnt_c !== cnt_tab[e]) begin
                    bad++; $display("FAIL full_count[%0d] got=%0d exp=%0d", e, cnt_c, cnt_tab[e]);
                end
            end
            if (e == 0 || e > 75) exp_o = 8'h00;
            else                  exp_o = words[(e - 1) / 15];
            total++;
            if (out_c !== exp_o || val_c !== (exp_o != 8'h00)) begin
                bad++;
                $display("FAIL full_word[%0d] got dout=%h valid=%b exp dout=%h valid=%b",
                         e, out_c, val_c, exp_o, (exp_o != 8'h00));
            end
        end
`ifdef DECO_OVF_EN
        total++;
        if (ovf_c !== 1'b1) begin bad++; $display("FAIL full_ovf got=%b exp=1", ovf_c); end
`endif
        total++;
        if (cnt_c !== 3'd0) begin bad++; $display("FAIL full_drain got=%0d exp=0", cnt_c); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            d_in_valid = 1'b1;
            d_in       = 3'(i + 1);
            step();
        end
        d_in_valid = 1'b0;
        total++;
        if (cnt_b !== 3'd2 || val_b !== 1'b1 || out_b !== 8'h02) begin
            bad++;
            $display("FAIL midrst_pre got cnt=%0d valid=%b dout=%h exp cnt=2 valid=1 dout=02",
                     cnt_b, val_b, out_b);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (out_b !== 8'h00 || val_b !== 1'b0 || cnt_b !== 3'd0) begin
            bad++;
            $display("FAIL midrst_clear got cnt=%0d valid=%b dout=%h exp cnt=0 valid=0 dout=00",
                     cnt_b, val_b, out_b);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (out_b !== 8'h00 || val_b !== 1'b0) begin
                bad++; $display("FAIL midrst_quiet[%0d] got dout=%h valid=%b exp dout=00 valid=0",
                                i, out_b, val_b);
            end
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        d_in_valid = 1'b0;
        d_in       = 3'd0;
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_full();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
